// File: rtl/seq_detector_cfg_pkg.sv
// Shared types and default values for the configurable serial pattern detector.
package seq_detector_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_ARMED = 2'b10
  } state_t;

  localparam int          PKG_PAT_W       = 4;
  localparam int          PKG_CNT_W       = 8;
  localparam logic [31:0] PKG_DEF_PATTERN = 32'hA;
  localparam bit          PKG_DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_shift_hist.sv
// Bit-history shift register with a fill counter that saturates at PAT_W.
// The shifted candidate is exported so the match can be judged on post-edge values.
module seq_shift_hist #(
  parameter int PAT_W = 4,
  parameter int FW    = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_i,
  input  logic             in_i,
  input  logic             flush_i,
  input  logic             keep_i,
  input  logic             match_i,
  output logic [PAT_W-1:0] hist_sh_o,
  output logic [FW-1:0]    fill_sh_o,
  output logic             full_d_o
);

  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;

  assign hist_sh_o = {hist_q[PAT_W-2:0], in_i};
  assign fill_sh_o = (fill_q == FULL) ? fill_q : fill_q + FW'(1);

  // A match without overlap consumes the whole window, so the next one starts empty.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (flush_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      if (match_i && !keep_i) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_sh_o;
        fill_d = fill_sh_o;
      end
    end
  end

  assign full_d_o = (fill_d == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_cfg.sv
// Serial bit-pattern detector with loadable pattern/mask/overlap, a registered
// match pulse and a saturating match counter.
module seq_detector_cfg
  import seq_detector_cfg_pkg::*;
#(
  parameter int               PAT_W       = PKG_PAT_W,
  parameter int               CNT_W       = PKG_CNT_W,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(PKG_DEF_PATTERN),
  parameter bit               DEF_OVERLAP = PKG_DEF_OVERLAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  localparam int            FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] pattern_q, mask_q;
  logic             overlap_q;
  logic             out_q;
  logic [CNT_W-1:0] cnt_q;
  state_t           state_q, state_d;

  logic             accept;
  logic             match_d;
  logic             full_d;
  logic [PAT_W-1:0] hist_sh;
  logic [FW-1:0]    fill_sh;

  // A configuration load wins over a coincident bit, which is dropped.
  assign accept  = en && in_valid && !cfg_load;
  assign match_d = accept && (fill_sh == FULL) &&
                   (((hist_sh ^ pattern_q) & mask_q) == '0);

  seq_shift_hist #(
    .PAT_W (PAT_W),
    .FW    (FW)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .shift_i   (accept),
    .in_i      (in),
    .flush_i   (cfg_load),
    .keep_i    (overlap_q),
    .match_i   (match_d),
    .hist_sh_o (hist_sh),
    .fill_sh_o (fill_sh),
    .full_d_o  (full_d)
  );

  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = en ? ST_FILL : ST_IDLE;
    end else if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = full_d ? ST_ARMED : ST_FILL;
        ST_FILL:  if (full_d) state_d = ST_ARMED;
        ST_ARMED: if (!full_d) state_d = ST_FILL;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= DEF_PATTERN;
      mask_q    <= '1;
      overlap_q <= DEF_OVERLAP;
      out_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= match_d;
      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        mask_q    <= cfg_mask;
        overlap_q <= cfg_overlap;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (match_d && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_seq_detector_cfg.sv
// Directed bench for seq_detector_cfg (PAT_W=4, CNT_W=2) with hand-computed expectations.
module tb_seq_detector_cfg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FILL  = 2'b01;
  localparam logic [1:0] S_ARMED = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic       din = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic [3:0] cfg_mask = 4'b0000;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       out;
  logic [1:0] match_cnt;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_cfg #(
    .PAT_W (4),
    .CNT_W (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .in_valid    (in_valid),
    .in          (din),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .out         (out),
    .match_cnt   (match_cnt),
    .state       (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic send(input logic b, input logic exp_out, input string tag);
    en       = 1'b1;
    in_valid = 1'b1;
    din      = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check(tag, out, exp_out);
  endtask

  task automatic load(input logic [3:0] pat, input logic [3:0] msk, input logic ovl);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_mask    = msk;
    cfg_overlap = ovl;
    en          = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  logic [6:0] t1_bits = 7'b0101010;
  logic [6:0] t1_outs = 7'b0000101;
  logic [6:0] t2_outs = 7'b0000100;

  initial begin
    #12 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_out", out, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_state", state, S_IDLE);

    // 1: default pattern 1010, overlap on
    for (int i = 0; i < 7; i++) send(t1_bits[6-i], t1_outs[6-i], $sformatf("t1_bit%0d", i + 1));
    check("t1_cnt", match_cnt, 2);
    check("t1_state", state, S_ARMED);

    // 2: overlap off
    clear_cnt();
    load(4'b1010, 4'b1111, 1'b0);
    check("t2_state_load", state, S_FILL);
    for (int i = 0; i < 5; i++) send(t1_bits[6-i], t2_outs[6-i], $sformatf("t2_bit%0d", i + 1));
    check("t2_state_after_match", state, S_FILL);
    for (int i = 5; i < 7; i++) send(t1_bits[6-i], t2_outs[6-i], $sformatf("t2_bit%0d", i + 1));
    check("t2_cnt", match_cnt, 1);

    // 3: mask 1101
    clear_cnt();
    load(4'b1010, 4'b1101, 1'b1);
    send(1, 0, "t3_a1"); send(0, 0, "t3_a2"); send(0, 0, "t3_a3"); send(0, 1, "t3_a4");
    send(0, 0, "t3_b1"); send(0, 0, "t3_b2"); send(0, 0, "t3_b3"); send(0, 0, "t3_b4");
    check("t3_cnt", match_cnt, 1);

    // 4: enable gap holds history
    clear_cnt();
    load(4'b1010, 4'b1111, 1'b1);
    send(1, 0, "t4_b1"); send(0, 0, "t4_b2");
    for (int i = 0; i < 3; i++) begin
      en = 1'b0; in_valid = 1'b1; din = 1'b1;
      @(posedge clk); #1;
      check($sformatf("t4_gap%0d_state", i), state, S_IDLE);
      check($sformatf("t4_gap%0d_out", i), out, 0);
    end
    in_valid = 1'b0;
    send(1, 0, "t4_b3");
    check("t4_state_resume", state, S_FILL);
    send(0, 1, "t4_b4");
    check("t4_cnt", match_cnt, 1);

    // 5: mask zero, counter saturation, clear vs increment
    clear_cnt();
    load(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 8; i++) send(i[0], (i >= 3), $sformatf("t5_bit%0d", i + 1));
    check("t5_cnt_sat", match_cnt, 3);
    cnt_clr = 1'b1;
    send(1, 1, "t5_clr_out");
    cnt_clr = 1'b0;
    check("t5_clr_cnt", match_cnt, 0);

    // 6: reset mid-stream
    load(4'b1010, 4'b1111, 1'b1);
    send(1, 0, "t6_p1"); send(0, 0, "t6_p2"); send(1, 0, "t6_p3");
    check("t6_pre_rst_state", state, S_FILL);
    rst = 1'b1;
    #2;
    check("t6_async_state", state, S_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, 0, "t6_after0");
    send(1, 0, "t6_q1"); send(0, 0, "t6_q2"); send(1, 0, "t6_q3"); send(0, 1, "t6_q4");

    // cfg_load with a coincident valid bit: that bit is dropped
    cfg_load = 1'b1; cfg_pattern = 4'b1010; cfg_mask = 4'b1111; cfg_overlap = 1'b1;
    en = 1'b1; in_valid = 1'b1; din = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0; in_valid = 1'b0;
    check("t6_load_out", out, 0);
    check("t6_load_state", state, S_FILL);
    send(0, 0, "t6_r1"); send(1, 0, "t6_r2"); send(0, 0, "t6_r3");
    check("t6_fill_not_full", state, S_FILL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
